// File: rtl/aes_decode_pkg.sv
// Shared constants for the AES MMIO command decoder: command encodings,
// instruction indices and the default decode window table.
package aes_decode_pkg;

   localparam int PKG_NUM_INSTR = 10;
   localparam int PKG_ADDR_W    = 16;
   localparam int PKG_DATA_W    = 8;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_RD   = 2'd1;
   localparam logic [1:0] CMD_WR   = 2'd2;

   typedef enum logic [3:0] {
      WRITE_ADDRESS = 4'd0,
      START_ENCRYPT = 4'd1,
      READ_LENGTH   = 4'd2,
      READ_ADDRESS  = 4'd3,
      READ_KEY      = 4'd4,
      READ_COUNTER  = 4'd5,
      GET_STATUS    = 4'd6,
      WRITE_LENGTH  = 4'd7,
      WRITE_KEY     = 4'd8,
      WRITE_COUNTER = 4'd9
   } instr_e;

   typedef logic [PKG_NUM_INSTR-1:0][1:0]            win_cmd_t;
   typedef logic [PKG_NUM_INSTR-1:0][PKG_ADDR_W-1:0] win_addr_t;
   typedef logic [PKG_NUM_INSTR-1:0][PKG_DATA_W-1:0] win_data_t;

   // Rows listed from index 9 down to index 0.
   localparam win_cmd_t WIN_CMD = {
      CMD_WR, CMD_WR, CMD_WR, CMD_RD, CMD_RD,
      CMD_RD, CMD_RD, CMD_RD, CMD_WR, CMD_WR
   };

   // Window lower bounds (inclusive).
   localparam win_addr_t WIN_LO = {
      16'hFF20, 16'hFF10, 16'hFF04, 16'hFF00, 16'hFF20,
      16'hFF10, 16'hFF02, 16'hFF04, 16'hFF00, 16'hFF02
   };

   // Window upper bounds (exclusive).
   localparam win_addr_t WIN_HI = {
      16'hFF30, 16'hFF20, 16'hFF06, 16'hFF01, 16'hFF30,
      16'hFF20, 16'hFF04, 16'hFF06, 16'hFF01, 16'hFF04
   };

   // A zero mask means the row ignores write data.
   localparam win_data_t WIN_DMASK = {
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'hFF, 8'h00
   };

   localparam win_data_t WIN_DVAL = {
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h01, 8'h00
   };

endpackage

// File: rtl/aes_decode_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count. The head entry
// reads as zero while empty. DEPTH must be a power of two.
module aes_decode_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     valid,
   output logic                     not_full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = {1'b1, {PW{1'b0}}};

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    do_push, do_pop;

   // Pointer, count and storage next-state; pointers wrap naturally.
   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      mem_d    = mem_q;
      if (do_push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Control state; reset drops every queued entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign valid    = (count_q != '0);
   assign not_full = (count_q != FULL_CNT);
   assign count    = count_q;
   assign dout     = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/aes_mmio_cmd_decode_q.sv
// Registered AES MMIO instruction decoder: classifies each accepted strobe
// against the window table and queues hits in an output FIFO.
// Optional per-instruction issue counters: define AES_DECODE_ISSUE_COUNT_EN.
module aes_mmio_cmd_decode_q
   import aes_decode_pkg::*;
#(
   parameter int ADDR_W    = PKG_ADDR_W,
   parameter int DATA_W    = PKG_DATA_W,
   parameter int NUM_INSTR = PKG_NUM_INSTR,
   parameter int DEPTH     = 4,
`ifdef AES_DECODE_ISSUE_COUNT_EN
   parameter int CNT_W     = 8,
`endif
   parameter logic [NUM_INSTR-1:0][1:0]        WIN_CMD_P   = WIN_CMD,
   parameter logic [NUM_INSTR-1:0][ADDR_W-1:0] WIN_LO_P    = WIN_LO,
   parameter logic [NUM_INSTR-1:0][ADDR_W-1:0] WIN_HI_P    = WIN_HI,
   parameter logic [NUM_INSTR-1:0][DATA_W-1:0] WIN_DMASK_P = WIN_DMASK,
   parameter logic [NUM_INSTR-1:0][DATA_W-1:0] WIN_DVAL_P  = WIN_DVAL
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stb,
   input  logic                          wr,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DATA_W-1:0]             data_in,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_INSTR-1:0]          out_onehot,
   output logic [$clog2(NUM_INSTR)-1:0]  out_idx,
   output logic [1:0]                    out_cmd,
   output logic [ADDR_W-1:0]             out_addr,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(DEPTH):0]        fifo_count,
   output logic                          err_nomatch,
   output logic                          err_multi
`ifdef AES_DECODE_ISSUE_COUNT_EN
   ,
   output logic [NUM_INSTR*CNT_W-1:0]    issue_cnt
`endif
);

   localparam int IW = $clog2(NUM_INSTR);
   localparam int EW = IW + 2 + ADDR_W + DATA_W;

   logic [1:0]           cmd;
   logic [NUM_INSTR-1:0] hit;
   logic [IW-1:0]        hit_idx;
   logic                 any_hit, multi_hit;
   logic                 accept, push, pop;
   logic [EW-1:0]        fifo_din, fifo_dout;
   logic                 err_nomatch_q, err_nomatch_d;
   logic                 err_multi_q, err_multi_d;

   // Window compare: command, half-open address range, optional data match.
   always_comb begin
      cmd = stb ? {wr, ~wr} : CMD_NONE;
      for (int i = 0; i < NUM_INSTR; i++) begin
         hit[i] = (cmd == WIN_CMD_P[i]) &&
                  (addr >= WIN_LO_P[i]) && (addr < WIN_HI_P[i]) &&
                  ((WIN_DMASK_P[i] == '0) ||
                   ((data_in & WIN_DMASK_P[i]) == WIN_DVAL_P[i]));
      end
   end

   // Priority encoder: lowest hitting index wins.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_INSTR - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = IW'(i);
      end
      any_hit   = |hit;
      multi_hit = |(hit & (hit - NUM_INSTR'(1)));
   end

   assign accept   = stb & in_ready;
   assign push     = accept & any_hit;
   assign pop      = out_valid & out_ready;
   assign fifo_din = {hit_idx, cmd, addr, data_in};

   aes_decode_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .din      (fifo_din),
      .pop      (pop),
      .dout     (fifo_dout),
      .valid    (out_valid),
      .not_full (in_ready),
      .count    (fifo_count)
   );

   assign {out_idx, out_cmd, out_addr, out_data} = fifo_dout;
   assign out_onehot = out_valid ? (NUM_INSTR'(1) << out_idx) : '0;

   // Error next-state: no-match pulses one cycle, multi-match is sticky.
   always_comb begin
      err_nomatch_d = accept & ~any_hit;
      err_multi_d   = err_multi_q | (push & multi_hit);
   end

   // Error flags register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_nomatch_q <= 1'b0;
         err_multi_q   <= 1'b0;
      end else begin
         err_nomatch_q <= err_nomatch_d;
         err_multi_q   <= err_multi_d;
      end
   end

   assign err_nomatch = err_nomatch_q;
   assign err_multi   = err_multi_q;

`ifdef AES_DECODE_ISSUE_COUNT_EN
   logic [NUM_INSTR-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Count pops per instruction, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         for (int i = 0; i < NUM_INSTR; i++) begin
            if ((out_idx == IW'(i)) && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Issue counter register.
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_aes_mmio_cmd_decode_q.sv
// Directed bench for aes_mmio_cmd_decode_q with a scoreboard of expected
// FIFO entries. Window 5 is widened down to FF1F so that FF1F overlaps
// windows 4 and 5.
module tb_aes_mmio_cmd_decode_q;
   import aes_decode_pkg::*;

   localparam logic [9:0][15:0] TB_WIN_LO = {WIN_LO[9:6], 16'hFF1F, WIN_LO[4:0]};

   typedef struct packed {
      logic [3:0]  idx;
      logic [1:0]  cmd;
      logic [15:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  data_in = '0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, err_nomatch, err_multi;
   logic [9:0]  out_onehot;
   logic [3:0]  out_idx;
   logic [1:0]  out_cmd;
   logic [15:0] out_addr;
   logic [7:0]  out_data;
   logic [2:0]  fifo_count;
`ifdef AES_DECODE_ISSUE_COUNT_EN
   logic [19:0] issue_cnt;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   aes_mmio_cmd_decode_q #(
      .WIN_LO_P (TB_WIN_LO)
`ifdef AES_DECODE_ISSUE_COUNT_EN
      , .CNT_W  (2)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stb         (stb),
      .wr          (wr),
      .addr        (addr),
      .data_in     (data_in),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_onehot  (out_onehot),
      .out_idx     (out_idx),
      .out_cmd     (out_cmd),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .fifo_count  (fifo_count),
      .err_nomatch (err_nomatch),
      .err_multi   (err_multi)
`ifdef AES_DECODE_ISSUE_COUNT_EN
      , .issue_cnt (issue_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare the head against the scoreboard if it pops at the coming edge,
   // then advance to just after that edge.
   task automatic step();
      exp_t e;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_underflow observed=pop expected=no_pop");
         end else begin
            e = sb.pop_front();
            chk("pop_entry", {out_idx, out_cmd, out_addr, out_data}, e);
            chk("pop_onehot", out_onehot, 10'(1) << e.idx);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [15:0] a, input logic [7:0] d);
      stb = 1'b1; wr = w; addr = a; data_in = d;
   endtask

   task automatic idle();
      stb = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
   endtask

   initial begin
      // Reset state
      step(); step();
      rst = 1'b1;
      chk("rst_count", fifo_count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_nomatch", err_nomatch, 0);
      chk("rst_multi", err_multi, 0);
      chk("rst_fields", {out_onehot, out_idx, out_cmd, out_addr, out_data}, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef AES_DECODE_ISSUE_COUNT_EN
      chk("rst_issue_cnt", issue_cnt, 0);
`endif

      // START_ENCRYPT, visible one cycle after acceptance
      drive(1'b1, 16'hFF00, 8'h01);
      sb.push_back('{4'd1, 2'd2, 16'hFF00, 8'h01});
      chk("no_bypass_valid", out_valid, 0);
      step(); idle();
      chk("se_valid", out_valid, 1);
      chk("se_idx", out_idx, 1);
      chk("se_onehot", out_onehot, 10'h002);
      chk("se_cmd", out_cmd, 2);
      chk("se_count", fifo_count, 1);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("se_drained", fifo_count, 0);

      // No-match cases: out of range, data mismatch, range upper bound
      drive(1'b0, 16'hFF30, 8'h00); step(); idle();
      chk("nm_pulse", err_nomatch, 1);
      chk("nm_count", fifo_count, 0);
      step();
      chk("nm_one_cycle", err_nomatch, 0);
      drive(1'b1, 16'hFF00, 8'h03); step(); idle();
      chk("nm_data_mask", err_nomatch, 1);
      drive(1'b0, 16'hFF06, 8'h00); step(); idle();
      chk("nm_hi_excl", err_nomatch, 1);
      chk("nm_hi_count", fifo_count, 0);

      // Five reads with consumer stalled: the fifth is dropped
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 16'hFF10 + 16'(i), 8'h00);
         chk("fill_in_ready", in_ready, (i < 4) ? 1 : 0);
         if (i < 4) sb.push_back('{4'd4, 2'd1, 16'hFF10 + 16'(i), 8'h00});
         step();
      end
      idle();
      chk("fill_count", fifo_count, 4);
      chk("fill_in_ready_lo", in_ready, 0);
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      chk("fill_drained", fifo_count, 0);

      // Simultaneous push and pop at occupancy 2
      drive(1'b0, 16'hFF05, 8'h00); sb.push_back('{4'd2, 2'd1, 16'hFF05, 8'h00}); step();
      drive(1'b0, 16'hFF02, 8'h00); sb.push_back('{4'd3, 2'd1, 16'hFF02, 8'h00}); step();
      chk("pp_pre_count", fifo_count, 2);
      drive(1'b1, 16'hFF21, 8'h5A); sb.push_back('{4'd9, 2'd2, 16'hFF21, 8'h5A});
      out_ready = 1'b1; step(); idle(); out_ready = 1'b0;
      chk("pp_count", fifo_count, 2);
      out_ready = 1'b1; step(); step(); out_ready = 1'b0;
      chk("pp_drained", fifo_count, 0);

      // Full FIFO: a pop does not let a same-cycle command in
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'hFF00, 8'h00); sb.push_back('{4'd6, 2'd1, 16'hFF00, 8'h00}); step();
      end
      drive(1'b1, 16'hFF10, 8'h00);
      out_ready = 1'b1;
      chk("full_in_ready", in_ready, 0);
      step(); idle(); out_ready = 1'b0;
      chk("full_pop_count", fifo_count, 3);
      chk("full_ready_back", in_ready, 1);
      out_ready = 1'b1; repeat (3) step(); out_ready = 1'b0;
      chk("full_drained", fifo_count, 0);
      chk("multi_clear_before", err_multi, 0);

      // Overlapping windows 4 and 5: lowest index wins, sticky flag
      drive(1'b0, 16'hFF1F, 8'h00); sb.push_back('{4'd4, 2'd1, 16'hFF1F, 8'h00}); step(); idle();
      chk("multi_set", err_multi, 1);
      chk("multi_pushed", fifo_count, 1);
      chk("multi_no_nomatch", err_nomatch, 0);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      repeat (10) step();
      chk("multi_sticky", err_multi, 1);
      rst = 1'b0; step(); rst = 1'b1;
      chk("multi_rst", err_multi, 0);

`ifdef AES_DECODE_ISSUE_COUNT_EN
      // Issue counters saturate at 3 with a 2-bit width
      chk("cnt_after_rst", issue_cnt, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'hFF04, 8'h00); sb.push_back('{4'd7, 2'd2, 16'hFF04, 8'h00}); step(); idle();
         out_ready = 1'b1; step(); out_ready = 1'b0;
      end
      chk("cnt_saturate", issue_cnt, 20'h0C000);
`endif

      // Reset with three entries queued discards them
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'hFF04, 8'h00); step();
      end
      idle();
      chk("rq_count", fifo_count, 3);
      chk("rq_valid", out_valid, 1);
      rst = 1'b0; step(); rst = 1'b1;
      chk("rq_count_rst", fifo_count, 0);
      chk("rq_valid_rst", out_valid, 0);
      chk("rq_fields_rst", {out_onehot, out_idx, out_cmd, out_addr, out_data}, 0);
`ifdef AES_DECODE_ISSUE_COUNT_EN
      chk("rq_cnt_rst", issue_cnt, 0);
`endif

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aes_mmio_cmd_decode_q.md
Name: aes_mmio_cmd_decode_q

Overview:
- Registered, parametrised successor to the AES ILA instruction decoder.
- Samples MMIO strobes from the 8051-side bus, classifies each against a window table, and buffers decoded instructions in a FIFO with a valid/ready output.
- Consumers: AQED issue logic and the ILA-RTL refinement checker.
- Adds over the combinational decoder: queueing, no-match and multi-match detection, and optional per-instruction issue counters.

Parameters:
- ADDR_W, 16, MMIO address width.
- DATA_W, 8, MMIO data width.
- NUM_INSTR, 10, number of decode windows (table rows in package).
- DEPTH, 4, output FIFO entries (power of 2, >=2).
- CNT_W, 8, issue-counter width (optional feature only).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- stb  in  1  MMIO strobe.
- wr  in  1  1 = write (cmd 2), 0 = read (cmd 1).
- addr  in  ADDR_W  MMIO address.
- data_in  in  DATA_W  MMIO write data.
- in_ready  out  1  command accepted when stb & in_ready.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- out_onehot  out  NUM_INSTR  decoded instruction, exactly one bit set.
- out_idx  out  $clog2(NUM_INSTR)  index of the set bit.
- out_cmd  out  2  1 = read, 2 = write.
- out_addr  out  ADDR_W  captured address.
- out_data  out  DATA_W  captured data.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- err_nomatch  out  1  one-cycle pulse: accepted command hit no window.
- err_multi  out  1  sticky: an accepted command hit more than one window.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - fifo_count = 0, out_valid = 0, err_nomatch = 0, err_multi = 0.
  - out_onehot, out_idx, out_cmd, out_addr and out_data read 0 while empty.
  - Counters clear.
  - Reset mid-operation discards all queued entries.
- Command encoding: cmd = {wr, ~wr} when stb, else 0. cmd 3 never occurs.
- in_ready = (fifo_count < DEPTH). It is combinational from state only, never from out_ready.
- Acceptance: stb & in_ready. stb while !in_ready is dropped; the master is required to hold stb.
- Hit test: window i hits when all of the following hold:
  - cmd == WIN_CMD[i];
  - WIN_LO[i] <= addr < WIN_HI[i], unsigned;
  - if WIN_DMASK[i] != 0, (data_in & WIN_DMASK[i]) == WIN_DVAL[i].
- Latency: an accepted command with at least one hit is written at that edge. out_valid rises the next cycle; the FIFO has no bypass.
- Zero hits: nothing is pushed. err_nomatch is high for exactly the cycle after acceptance.
- Multiple hits: the lowest index wins, the entry is pushed, and err_multi is set. err_multi clears only on reset.
- Simultaneous push and pop: allowed at any occupancy below DEPTH; count is unchanged. When full, a pop frees a slot, but in_ready only rises the following cycle.
- Pointers wrap modulo DEPTH. Output fields are registered FIFO-head reads and stay stable while out_valid & !out_ready.
- Default window table (package), as index: cmd [lo, hi) data:
  - 0 WRITE_ADDRESS: 2 [FF02, FF04).
  - 1 START_ENCRYPT: 2 [FF00, FF01), data == 01.
  - 2 READ_LENGTH: 1 [FF04, FF06).
  - 3 READ_ADDRESS: 1 [FF02, FF04).
  - 4 READ_KEY: 1 [FF10, FF20).
  - 5 READ_COUNTER: 1 [FF20, FF30).
  - 6 GET_STATUS: 1 [FF00, FF01).
  - 7 WRITE_LENGTH: 2 [FF04, FF06).
  - 8 WRITE_KEY: 2 [FF10, FF20).
  - 9 WRITE_COUNTER: 2 [FF20, FF30).

Optional Feature:
- Macro: AES_DECODE_ISSUE_COUNT_EN.
- With the macro:
  - Adds output port issue_cnt, NUM_INSTR*CNT_W, packed with index i at [i*CNT_W +: CNT_W].
  - Entry i increments on every pop whose out_idx == i.
  - Counters saturate at all-ones and clear on reset.
- Without the macro: the port and counters are absent and all other behaviour is identical.

Decomposition:
- Package aes_decode_pkg holds:
  - the cmd encodings CMD_NONE/CMD_RD/CMD_WR;
  - the instruction index enum;
  - the WIN_CMD/WIN_LO/WIN_HI/WIN_DMASK/WIN_DVAL constant arrays.
- Sub-module aes_decode_fifo: generic DEPTH x width synchronous FIFO with count. The top holds only the window compare, priority encoder, error logic and counters.

Test Plan:
- Reset, then stb=1 wr=1 addr=FF00 data=01 → the next cycle out_valid=1, out_idx=1, out_onehot=0x002, out_cmd=2, fifo_count=1.
- stb=1 wr=0 addr=FF30 → no push, err_nomatch pulses 1 cycle, fifo_count stays 0.
- Hold out_ready=0 and issue 5 reads at FF10..FF14 → 4 accepted, in_ready=0 after the 4th, the 5th dropped. Then pop all with out_ready=1 → idx 4 x4 in order, addr FF10..FF13.
- FIFO at 2 entries, push write addr FF21 and pop at the same edge → fifo_count stays 2 and the newest entry has idx 9.
- Override the table so windows 4 and 5 overlap at FF1F, issue a read at FF1F → idx 4 pushed, err_multi=1 and still 1 after 10 idle cycles, cleared by rst=0.
- With AES_DECODE_ISSUE_COUNT_EN and CNT_W=2, pop 5 writes to FF04 → issue_cnt[7] = 3 (saturated), all others 0. Assert rst=0 with 3 queued → fifo_count=0 and out_valid=0 the cycle after.
